sd_dat_pio: RTL and testbench

SD_DAT_PIO -- requirements
Module: sd_dat_pio

---
 rtl/sd_dat_pio.sv | 159 +++++++++++++++
 tb/tb_sd_dat_pio.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_pio.sv
// ---------------------------------------------------------------------------
// sd_dat_pio
//
// Memory-mapped parallel I/O block for the SD card DAT lines.  Each of the
// WIDTH pad lines can independently be driven from an output register or
// left high-Z and sampled through a multi-flop synchroniser.  Optional edge
// capture with a maskable level interrupt is included when the macro
// SD_DAT_PIO_EDGE_CAPTURE_EN is defined; without it the edge/mask registers
// do not exist, their addresses read 0 and irq is tied low.
//
// Register map (address):
//   0 DATA     rd: synchronised pad value   wr: data_out
//   1 DIR      1 = drive the line
//   2 IRQMASK  interrupt enable per bit      (edge capture build only)
//   3 EDGECAP  captured edges, write-1-clear (edge capture build only)
//   4 OUTSET   wr: data_out |= writedata,   rd: 0
//   5 OUTCLR   wr: data_out &= ~writedata,  rd: 0
//   6-7        reserved, read 0, writes ignored
//
// Parameters:
//   WIDTH        number of bidirectional data lines (1..32)
//   SYNC_STAGES  input synchroniser depth (2..4)
//
// Ports:
//   clk         single clock for all logic
//   reset       synchronous, active-high reset
//   address     register select
//   chipselect  slave select (writes only)
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   bidir_port  pad-side data lines
//   irq         registered level interrupt request
// ---------------------------------------------------------------------------
module sd_dat_pio #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] irqmask_rd;
    logic [WIDTH-1:0] edgecap_rd;

    assign wr_en    = chipselect & ~write_n;
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Output data and direction registers.  OUTSET/OUTCLR give atomic
    // bit set/clear without a read-modify-write from software.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            dir      <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out <= writedata;
                ADDR_DIR:    dir      <= writedata;
                ADDR_OUTSET: data_out <= data_out | writedata;
                ADDR_OUTCLR: data_out <= data_out & ~writedata;
                default:     ;
            endcase
        end
    end

    // Per-bit tristate: a line is driven only while its DIR bit is set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end

    // Pad synchroniser.  Cleared on reset so that nothing seen on the pads
    // during reset can later look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bidir_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef SD_DAT_PIO_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] sync_prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_clr;

    // Any transition (rise or fall) of the synchronised value is an edge.
    // Works regardless of DIR, so driven lines see their own toggles.
    assign edge_hit = sync_out ^ sync_prev;
    assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;

    // Edge capture and mask.  The set term is OR'd in after the clear so a
    // new edge arriving in the same cycle as its write-1-clear is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev <= '0;
            irqmask   <= '0;
            edgecap   <= '0;
            irq       <= 1'b0;
        end else begin
            sync_prev <= sync_out;
            edgecap   <= (edgecap & ~edge_clr) | edge_hit;
            irq       <= |(edgecap & irqmask);
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata;
            end
        end
    end

    assign irqmask_rd = irqmask;
    assign edgecap_rd = edgecap;
`else
    assign irqmask_rd = '0;
    assign edgecap_rd = '0;
    assign irq        = 1'b0;
`endif

    // Read data is registered every cycle from the addressed source;
    // chipselect is intentionally not required for reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:    readdata <= sync_out;
                ADDR_DIR:     readdata <= dir;
                ADDR_IRQMASK: readdata <= irqmask_rd;
                ADDR_EDGECAP: readdata <= edgecap_rd;
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_pio.sv
// ---------------------------------------------------------------------------
// tb_sd_dat_pio
//
// Directed testbench for sd_dat_pio with WIDTH=4, SYNC_STAGES=2.  Each task
// starts and ends on a falling clock edge; inputs change there and outputs
// are sampled there, half a cycle away from the active rising edge.  The
// pads are shared with a per-bit external driver (ext_en/ext_drv) so the
// bench can play the role of the card.
// ---------------------------------------------------------------------------
module tb_sd_dat_pio;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic             clk;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    wire  [WIDTH-1:0] pad;
    logic             irq;

    logic [WIDTH-1:0] ext_en;
    logic [WIDTH-1:0] ext_drv;

    int checks;
    int failures;

    sd_dat_pio #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bidir_port (pad),
        .irq        (irq)
    );

    // External (card-side) driver on each pad line.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ext
        assign pad[i] = ext_en[i] ? ext_drv[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register write committed on the next rising edge; returns on the
    // following falling edge with the bus idle.
    task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Register read: address presented now, registered data one edge later.
    task automatic do_read(input logic [2:0] a, output logic [WIDTH-1:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] rd;
        reset = 1'b1;
        wait_cycles(2);
        checks++;
        if (readdata !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 4'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq: got %b expected %b", irq, 1'b0);
        end
        reset = 1'b0;
        do_read(3'd1, rd);
        checks++;
        if (rd !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_dir: got %h expected %h", rd, 4'h0);
        end
    endtask

    task automatic test_drive();
        logic [WIDTH-1:0] rd;
        ext_en = 4'h0;
        do_write(3'd1, 4'hF);
        do_write(3'd0, 4'hA);
        checks++;
        if (pad !== 4'hA) begin
            failures++;
            $display("[TB] FAIL drive_pad: got %b expected %b", pad, 4'b1010);
        end
        address = 3'd0;
        wait_cycles(SYNC + 2);
        checks++;
        if (readdata !== 4'hA) begin
            failures++;
            $display("[TB] FAIL drive_readback: got %h expected %h", readdata, 4'hA);
        end
        do_read(3'd1, rd);
        checks++;
        if (rd !== 4'hF) begin
            failures++;
            $display("[TB] FAIL drive_dir_read: got %h expected %h", rd, 4'hF);
        end
    endtask

    task automatic test_mixed_dir();
        do_write(3'd1, 4'h3);
        ext_drv = 4'b0100;
        ext_en  = 4'b1100;
        do_write(3'd0, 4'hF);
        checks++;
        if (pad !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL mixed_pad: got %b expected %b", pad, 4'b0111);
        end
        address = 3'd0;
        wait_cycles(SYNC + 2);
        checks++;
        if (readdata !== 4'h7) begin
            failures++;
            $display("[TB] FAIL mixed_readback: got %h expected %h", readdata, 4'h7);
        end
    endtask

    task automatic test_set_clr();
        logic [WIDTH-1:0] rd;
        ext_en = 4'h0;
        do_write(3'd1, 4'hF);
        do_write(3'd0, 4'h5);
        do_write(3'd4, 4'h2);
        checks++;
        if (pad !== 4'h7) begin
            failures++;
            $display("[TB] FAIL outset_pad: got %h expected %h", pad, 4'h7);
        end
        do_write(3'd5, 4'h1);
        checks++;
        if (pad !== 4'h6) begin
            failures++;
            $display("[TB] FAIL outclr_pad: got %h expected %h", pad, 4'h6);
        end
        // Reserved addresses: writes ignored, reads of 4..7 return 0.
        do_write(3'd6, 4'hF);
        do_write(3'd7, 4'h0);
        checks++;
        if (pad !== 4'h6) begin
            failures++;
            $display("[TB] FAIL reserved_write: got %h expected %h", pad, 4'h6);
        end
        for (int a = 4; a < 8; a++) begin
            do_read(3'(a), rd);
            checks++;
            if (rd !== 4'h0) begin
                failures++;
                $display("[TB] FAIL read_addr%0d: got %h expected %h", a, rd, 4'h0);
            end
        end
    endtask

`ifdef SD_DAT_PIO_EDGE_CAPTURE_EN
    task automatic test_edge_irq();
        logic [WIDTH-1:0] rd;
        do_write(3'd1, 4'h0);
        ext_drv = 4'h0;
        ext_en  = 4'hF;
        wait_cycles(SYNC + 3);
        do_write(3'd3, 4'hF);
        do_write(3'd2, 4'h4);
        wait_cycles(2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_irq_idle: got %b expected %b", irq, 1'b0);
        end
        ext_drv = 4'b0100;
        wait_cycles(SYNC + 3);
        do_read(3'd3, rd);
        checks++;
        if (rd !== 4'h4) begin
            failures++;
            $display("[TB] FAIL edgecap_set: got %h expected %h", rd, 4'h4);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL edge_irq_set: got %b expected %b", irq, 1'b1);
        end
        do_write(3'd3, 4'h4);
        wait_cycles(1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_irq_clear: got %b expected %b", irq, 1'b0);
        end
        // Re-arm, then time a falling edge so its capture lands on the same
        // rising edge as the write-1-clear: the set must survive.
        ext_drv = 4'b0000;
        wait_cycles(2);
        do_write(3'd3, 4'h4);
        do_read(3'd3, rd);
        checks++;
        if (rd !== 4'h4) begin
            failures++;
            $display("[TB] FAIL edgecap_set_wins: got %h expected %h", rd, 4'h4);
        end
        do_write(3'd3, 4'hF);
        do_read(3'd3, rd);
        checks++;
        if (rd !== 4'h0) begin
            failures++;
            $display("[TB] FAIL edgecap_w1c: got %h expected %h", rd, 4'h0);
        end
        ext_en = 4'h0;
    endtask
`else
    task automatic test_no_edge();
        logic [WIDTH-1:0] rd;
        do_write(3'd1, 4'h0);
        do_write(3'd2, 4'hF);
        do_write(3'd3, 4'hF);
        ext_en = 4'hF;
        for (int k = 0; k < 4; k++) begin
            ext_drv = (k % 2 == 0) ? 4'hF : 4'h0;
            wait_cycles(SYNC + 2);
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("[TB] FAIL noedge_irq_%0d: got %b expected %b", k, irq, 1'b0);
            end
        end
        do_read(3'd2, rd);
        checks++;
        if (rd !== 4'h0) begin
            failures++;
            $display("[TB] FAIL noedge_addr2: got %h expected %h", rd, 4'h0);
        end
        do_read(3'd3, rd);
        checks++;
        if (rd !== 4'h0) begin
            failures++;
            $display("[TB] FAIL noedge_addr3: got %h expected %h", rd, 4'h0);
        end
        ext_en = 4'h0;
    endtask
`endif

    task automatic test_reset_mid_write();
        logic [WIDTH-1:0] rd;
        ext_en = 4'h0;
        do_write(3'd1, 4'hF);
        do_write(3'd0, 4'hA);
        address = 3'd0;
        wait_cycles(SYNC + 2);
        reset = 1'b1;
        do_write(3'd0, 4'h3);
        reset = 1'b0;
        checks++;
        if (readdata !== 4'h0) begin
            failures++;
            $display("[TB] FAIL midreset_readdata: got %h expected %h", readdata, 4'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_irq: got %b expected %b", irq, 1'b0);
        end
        // Lines must be released: an external 0101 is seen unaltered.
        ext_drv = 4'b0101;
        ext_en  = 4'hF;
        wait_cycles(1);
        checks++;
        if (pad !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL midreset_highz: got %b expected %b", pad, 4'b0101);
        end
        do_read(3'd1, rd);
        checks++;
        if (rd !== 4'h0) begin
            failures++;
            $display("[TB] FAIL midreset_dir: got %h expected %h", rd, 4'h0);
        end
        // data_out must be 0, not the 3 that was written during reset.
        ext_en = 4'h0;
        do_write(3'd1, 4'hF);
        checks++;
        if (pad !== 4'h0) begin
            failures++;
            $display("[TB] FAIL midreset_write_lost: got %h expected %h", pad, 4'h0);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        ext_en     = '0;
        ext_drv    = '0;
        @(negedge clk);
        test_reset();
        test_drive();
        test_mixed_dir();
        test_set_clr();
`ifdef SD_DAT_PIO_EDGE_CAPTURE_EN
        test_edge_irq();
`else
        test_no_edge();
`endif
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
